// File: rtl/ps2_mouse_packet.sv
// rtl/ps2_mouse_packet.sv - PS/2 frame checker and 3-byte mouse packet assembler
module ps2_mouse_packet #(
  parameter int TIMEOUT = 200000,
  parameter int TW      = 18
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        word_ready,
  input  logic [10:0] frame,
  output logic        packet_valid,
  output logic [2:0]  buttons,
  output logic [8:0]  dx,
  output logic [8:0]  dy,
  output logic        x_ovf,
  output logic        y_ovf,
  output logic        frame_err,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    WAIT_X   = 2'd1,
    WAIT_Y   = 2'd2
  } state_t;

  localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT);

  state_t          state;
  logic            wr_q;
  logic [TW-1:0]   timer;
  // Header without the always-one bit3: {y_ovf, x_ovf, y_sign, x_sign, buttons}
  logic [6:0]      hdr;
  logic [7:0]      xbyte;
  logic [7:0]      data;
  logic            byte_event;
  logic            frame_ok;
  logic            timed_out;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Data bits arrive LSB first, so D0 sits at the top of the frame.
  always_comb begin
    data = '0;
    for (int i = 0; i < 8; i++) begin
      data[i] = frame[9-i];
    end
  end

  assign byte_event = word_ready & ~wr_q;
  assign frame_ok   = ~frame[10] & frame[0] & (^frame[9:1]);
  assign timed_out  = (state != WAIT_HDR) && (timer == TIMEOUT_W);

  // Packet FSM with registered outputs; byte events take priority over timeout expiry.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state        <= WAIT_HDR;
      wr_q         <= 1'b0;
      timer        <= '0;
      hdr          <= '0;
      xbyte        <= '0;
      packet_valid <= 1'b0;
      buttons      <= '0;
      dx           <= '0;
      dy           <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
      frame_err    <= 1'b0;
      sync_err     <= 1'b0;
      err_count    <= '0;
    end else begin
      wr_q         <= word_ready;
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;
      sync_err     <= 1'b0;
      if (byte_event) begin
        timer <= '0;
        if (!frame_ok) begin
          frame_err <= 1'b1;
          err_count <= sat_inc(err_count);
          state     <= WAIT_HDR;
        end else begin
          case (state)
            WAIT_HDR: begin
              if (data[3]) begin
                hdr   <= {data[7:4], data[2:0]};
                state <= WAIT_X;
              end else begin
                sync_err  <= 1'b1;
                err_count <= sat_inc(err_count);
              end
            end
            WAIT_X: begin
              xbyte <= data;
              state <= WAIT_Y;
            end
            WAIT_Y: begin
              packet_valid <= 1'b1;
              buttons      <= hdr[2:0];
              dx           <= {hdr[3], xbyte};
              dy           <= {hdr[4], data};
              x_ovf        <= hdr[5];
              y_ovf        <= hdr[6];
              state        <= WAIT_HDR;
            end
            default: state <= WAIT_HDR;
          endcase
        end
      end else if (timed_out) begin
        sync_err  <= 1'b1;
        err_count <= sat_inc(err_count);
        state     <= WAIT_HDR;
        timer     <= '0;
      end else if (state != WAIT_HDR && timer != TIMEOUT_W) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// tb/tb_ps2_mouse_packet.sv - table, directed and random checks of ps2_mouse_packet
module tb_ps2_mouse_packet;

  localparam int TO = 40;

  logic        ck;
  logic        reset;
  logic        word_ready;
  logic [10:0] frame;
  logic        packet_valid;
  logic [2:0]  buttons;
  logic [8:0]  dx;
  logic [8:0]  dy;
  logic        x_ovf;
  logic        y_ovf;
  logic        frame_err;
  logic        sync_err;
  logic [7:0]  err_count;

  ps2_mouse_packet #(.TIMEOUT(TO), .TW(6)) dut (
    .ck(ck), .reset(reset), .word_ready(word_ready), .frame(frame),
    .packet_valid(packet_valid), .buttons(buttons), .dx(dx), .dy(dy),
    .x_ovf(x_ovf), .y_ovf(y_ovf), .frame_err(frame_err), .sync_err(sync_err),
    .err_count(err_count)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_vec = 0;
  int n_bad = 0;
  int pv_n = 0;
  int fe_n = 0;
  int se_n = 0;

  // Reference model: received bytes of the packet in progress plus arrival time of the last one.
  logic [7:0] q[$];
  int         t = 0;
  int         last_t = 0;
  logic       m_prev_wr;
  logic       e_pv, e_fe, e_se, e_xo, e_yo;
  logic [2:0] e_btn;
  logic [8:0] e_dx, e_dy;
  logic [7:0] e_cnt;

  typedef struct {
    logic [10:0] f0, f1, f2;
    logic [2:0]  btn;
    logic [8:0]  dx, dy;
    logic        xo, yo;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[9-i] = b[i];
    f[1] = (~^b) ^ bad_par;
    f[0] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_prev_wr = 1'b0;
    e_pv = 0; e_fe = 0; e_se = 0; e_xo = 0; e_yo = 0;
    e_btn = '0; e_dx = '0; e_dy = '0; e_cnt = '0;
  endtask

  task automatic model_cycle(input logic wr, input logic [10:0] fr);
    logic       ev;
    logic       ok;
    logic [7:0] b;
    logic [7:0] h;
    ev = wr && !m_prev_wr;
    m_prev_wr = wr;
    e_pv = 0; e_fe = 0; e_se = 0;
    for (int i = 0; i < 8; i++) b[i] = fr[9-i];
    ok = (fr[10] == 1'b0) && (fr[0] == 1'b1) && ($countones(fr[9:1]) % 2 == 1);
    if (ev) begin
      if (!ok) begin
        e_fe = 1;
        q.delete();
      end else if (q.size() == 0) begin
        if (b[3]) begin q.push_back(b); last_t = t; end
        else e_se = 1;
      end else if (q.size() == 1) begin
        q.push_back(b);
        last_t = t;
      end else begin
        h = q[0];
        e_pv  = 1;
        e_btn = h[2:0];
        e_dx  = {h[4], q[1]};
        e_dy  = {h[5], b};
        e_xo  = h[6];
        e_yo  = h[7];
        q.delete();
      end
    end else if (q.size() > 0 && (t - last_t) == TO + 1) begin
      e_se = 1;
      q.delete();
    end
    if ((e_fe || e_se) && e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    t++;
  endtask

  task automatic step(input logic wr, input logic [10:0] fr);
    word_ready = wr;
    frame = fr;
    model_cycle(wr, fr);
    @(posedge ck);
    #1;
    pv_n += int'(packet_valid);
    fe_n += int'(frame_err);
    se_n += int'(sync_err);
    chk("cycle_outputs",
        {30'd0, packet_valid, buttons, dx, dy, x_ovf, y_ovf, frame_err, sync_err, err_count},
        {30'd0, e_pv, e_btn, e_dx, e_dy, e_xo, e_yo, e_fe, e_se, e_cnt});
  endtask

  task automatic send(input logic [10:0] fr, input int gap);
    step(1'b1, fr);
    repeat (gap) step(1'b0, fr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    word_ready = 1'b0;
    #1;
    chk("reset_outputs",
        {30'd0, packet_valid, buttons, dx, dy, x_ovf, y_ovf, frame_err, sync_err, err_count},
        64'd0);
    model_reset();
    pv_n = 0; fe_n = 0; se_n = 0;
    @(posedge ck);
    #1;
    reset = 1'b0;
  endtask

  task automatic good_packet();
    send(11'h243, 10);
    send(11'h283, 10);
    send(11'h283, 10);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rb;
    logic [10:0] rf;
    logic [10:0] one;
    int          gap;
    int          hold;

    tbl[0] = '{11'h243, 11'h283, 11'h283, 3'b001, 9'h005, 9'h005, 1'b0, 1'b0};
    tbl[1] = '{11'h251, 11'h283, 11'h1FD, 3'b001, 9'h005, 9'h1FE, 1'b0, 1'b0};
    tbl[2] = '{mkframe(8'hFF, 1'b0), mkframe(8'h80, 1'b0), mkframe(8'h01, 1'b0),
               3'b111, 9'h180, 9'h101, 1'b1, 1'b1};
    tbl[3] = '{mkframe(8'h1A, 1'b0), mkframe(8'h00, 1'b0), mkframe(8'h7F, 1'b0),
               3'b010, 9'h100, 9'h07F, 1'b0, 1'b0};

    word_ready = 1'b0;
    frame = '0;
    reset = 1'b1;
    do_reset();

    // Table of complete packets
    for (int k = 0; k < 4; k++) begin
      pv_n = 0;
      send(tbl[k].f0, 20);
      send(tbl[k].f1, 20);
      send(tbl[k].f2, 20);
      chk("tbl_packet_count", 64'(pv_n), 64'd1);
      chk("tbl_fields", {45'd0, buttons, dx, dy, x_ovf, y_ovf},
          {45'd0, tbl[k].btn, tbl[k].dx, tbl[k].dy, tbl[k].xo, tbl[k].yo});
      chk("tbl_err_count", 64'(err_count), 64'd0);
    end

    // Parity error mid-packet, then recovery
    do_reset();
    send(11'h243, 10);
    send(11'h241, 10);
    chk("parity_frame_err", 64'(fe_n), 64'd1);
    chk("parity_no_packet", 64'(pv_n), 64'd0);
    chk("parity_err_count", 64'(err_count), 64'd1);
    good_packet();
    chk("parity_recover_pv", 64'(pv_n), 64'd1);
    chk("parity_recover_fields", {45'd0, buttons, dx, dy, x_ovf, y_ovf},
        {45'd0, 3'b001, 9'h005, 9'h005, 2'b00});

    // Misaligned header byte
    do_reset();
    send(11'h201, 10);
    chk("misalign_sync_err", 64'(se_n), 64'd1);
    chk("misalign_err_count", 64'(err_count), 64'd1);
    good_packet();
    chk("misalign_recover_pv", 64'(pv_n), 64'd1);
    chk("misalign_fields", {45'd0, buttons, dx, dy, x_ovf, y_ovf},
        {45'd0, 3'b001, 9'h005, 9'h005, 2'b00});

    // Inter-byte timeout
    do_reset();
    send(11'h243, TO + 10);
    send(11'h283, 10);
    send(11'h283, 10);
    chk("timeout_sync_errs", 64'(se_n), 64'd3);
    chk("timeout_err_count", 64'(err_count), 64'd3);
    chk("timeout_no_packet", 64'(pv_n), 64'd0);

    // Byte arriving in the expiry cycle is still accepted
    do_reset();
    send(11'h243, TO);
    send(11'h283, TO);
    send(11'h283, 5);
    chk("expiry_edge_pv", 64'(pv_n), 64'd1);
    chk("expiry_edge_no_sync", 64'(se_n), 64'd0);

    // One cycle later the partial packet is gone
    do_reset();
    send(11'h243, TO + 1);
    chk("expiry_late_sync", 64'(se_n), 64'd1);

    // word_ready held high counts once
    do_reset();
    repeat (5) step(1'b1, 11'h243);
    repeat (3) step(1'b0, 11'h243);
    send(11'h283, 10);
    send(11'h283, 10);
    chk("level_pv", 64'(pv_n), 64'd1);
    chk("level_fields", {45'd0, buttons, dx, dy, x_ovf, y_ovf},
        {45'd0, 3'b001, 9'h005, 9'h005, 2'b00});
    chk("level_err_count", 64'(err_count), 64'd0);

    // Reset mid-packet clears outputs at once, then decoding resumes
    send(11'h251, 5);
    send(11'h283, 5);
    do_reset();
    good_packet();
    chk("reset_recover_pv", 64'(pv_n), 64'd1);
    chk("reset_recover_fields", {45'd0, buttons, dx, dy, x_ovf, y_ovf},
        {45'd0, 3'b001, 9'h005, 9'h005, 2'b00});

    // Error counter saturation
    do_reset();
    repeat (260) send(11'h241, 1);
    chk("sat_frame_errs", 64'(fe_n), 64'd260);
    chk("sat_err_count", 64'(err_count), 64'd255);

    // Random traffic against the model
    do_reset();
    one = 11'h001;
    for (int n = 0; n < 400; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 2) != 0) rb[3] = 1'b1;
      rf = mkframe(rb, 1'b0);
      if ($urandom_range(0, 9) < 2) rf = rf ^ (one << $urandom_range(0, 10));
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 4)) : 1;
      case ($urandom_range(0, 9))
        0:       gap = TO - 2 + int'($urandom_range(0, 4));
        default: gap = int'($urandom_range(1, 8));
      endcase
      repeat (hold) step(1'b1, rf);
      repeat (gap) step(1'b0, rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
